// File: rtl/serial_adder.sv
// Bit-serial add/subtract unit: one full-adder cell and a carry flop process
// WIDTH-bit operands LSB-first, with a start/ready/done handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             s_bit, c_nxt;
  logic [WIDTH-1:0] sum_nxt, a_nxt, b_nxt;

  always_comb begin
    s_bit   = a_sh[0] ^ b_sh[0] ^ c;
    c_nxt   = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
    // Whole-vector shifts keep WIDTH=1 legal (no empty part-selects).
    sum_nxt = sum >> 1;
    sum_nxt[WIDTH-1] = s_bit;
    a_nxt   = a_sh >> 1;
    b_nxt   = b_sh >> 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ready    <= 1'b1;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      c        <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            c     <= cin ^ sub;
            cnt   <= '0;
            ready <= 1'b0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh <= a_nxt;
          b_sh <= b_nxt;
          sum  <= sum_nxt;
          c    <= c_nxt;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            // c is still the carry into the MSB here; c_nxt is the carry out.
            cout     <= c_nxt;
            overflow <= c ^ c_nxt;
            done     <= 1'b1;
            ready    <= 1'b1;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 and WIDTH=1 instances, expected
// results from plain integer arithmetic, checked when done pulses.
module tb_serial_adder;

  localparam int W8 = 8;
  localparam int W1 = 1;

  typedef struct {
    logic [7:0] s;
    logic       co;
    logic       ov;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  logic          start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
  logic [W8-1:0] a8 = '0, b8 = '0;
  logic          ready8, done8, cout8, ovf8;
  logic [W8-1:0] sum8;

  logic          start1 = 1'b0, cin1 = 1'b0, sub1 = 1'b0;
  logic [W1-1:0] a1 = '0, b1 = '0;
  logic          ready1, done1, cout1, ovf1;
  logic [W1-1:0] sum1;

  exp_t q8[$];
  exp_t q1[$];
  int   nchk = 0;
  int   nbad = 0;

  serial_adder #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .ready(ready8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
  );

  serial_adder #(.WIDTH(W1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
    .ready(ready1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: w-bit two's complement add/subtract from plain arithmetic.
  function automatic exp_t model(input int w, input int a, input int b,
                                 input bit cin, input bit sub, input int due);
    exp_t e;
    int mask, bb, t, s;
    mask = (1 << w) - 1;
    bb   = sub ? (~b & mask) : (b & mask);
    t    = (a & mask) + bb + (sub ? int'(!cin) : int'(cin));
    s    = t & mask;
    e.s  = 8'(s);
    e.co = t[w];
    e.ov = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
    e.due = due;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && done8) begin
      if (q8.size() == 0) begin
        nchk++; nbad++;
        $display("FAIL done8_unexpected: got done=1 expected no pulse (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("sum8", int'(sum8), int'(e.s));
        chk("cout8", int'(cout8), int'(e.co));
        chk("ovf8", int'(ovf8), int'(e.ov));
        chk("latency8", cyc, e.due);
        chk("ready8_in_done", int'(ready8), 1);
      end
    end
    if (!rst && done1) begin
      if (q1.size() == 0) begin
        nchk++; nbad++;
        $display("FAIL done1_unexpected: got done=1 expected no pulse (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("sum1", int'(sum1), int'(e.s[0]));
        chk("cout1", int'(cout1), int'(e.co));
        chk("ovf1", int'(ovf1), int'(e.ov));
        chk("latency1", cyc, e.due);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accept edge.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                        input bit cin, input bit sub);
    int n = 0;
    while (!ready8 && n < 100) begin @(posedge clk); #1; n++; end
    if (!ready8) begin
      nchk++; nbad++;
      $display("FAIL ready8_timeout: got ready=0 expected 1 (cycle %0d)", cyc);
    end
    a8 = a; b8 = b; cin8 = cin; sub8 = sub; start8 = 1'b1;
    @(posedge clk); #1;
    q8.push_back(model(W8, int'(a), int'(b), cin, sub, cyc + W8));
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
  endtask

  task automatic issue1(input bit a, input bit b, input bit cin, input bit sub);
    int n = 0;
    while (!ready1 && n < 100) begin @(posedge clk); #1; n++; end
    if (!ready1) begin
      nchk++; nbad++;
      $display("FAIL ready1_timeout: got ready=0 expected 1 (cycle %0d)", cyc);
    end
    a1 = a; b1 = b; cin1 = cin; sub1 = sub; start1 = 1'b1;
    @(posedge clk); #1;
    q1.push_back(model(W1, int'(a), int'(b), cin, sub, cyc + W1));
    start1 = 1'b0;
    a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom); sub1 = 1'($urandom);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready8", int'(ready8), 1);
    chk("rst_done8", int'(done8), 0);
    chk("rst_sum8", int'(sum8), 0);
    chk("rst_cout8", int'(cout8), 0);
    chk("rst_ovf8", int'(ovf8), 0);
    chk("rst_ready1", int'(ready1), 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // WIDTH=1: full-adder truth table in both modes
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      issue1(v[0], v[1], v[2], v[3]);
    end

    // WIDTH=8 directed corners
    issue8(8'hFF, 8'h01, 1'b0, 1'b0);
    issue8(8'h7F, 8'h01, 1'b0, 1'b0);
    issue8(8'h05, 8'h07, 1'b0, 1'b1);
    issue8(8'h05, 8'h07, 1'b1, 1'b1);
    issue8(8'h80, 8'h01, 1'b0, 1'b1);

    // start while running is ignored
    issue8(8'h10, 8'h20, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;

    // reset in the middle of a run aborts with no done pulse
    issue8(8'h33, 8'h44, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("abort_ready8", int'(ready8), 1);
    chk("abort_done8", int'(done8), 0);
    chk("abort_sum8", int'(sum8), 0);
    q8.delete();
    q1.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (W8 + 2) begin @(posedge clk); #1; end
    issue8(8'h0F, 8'h01, 1'b0, 1'b0);

    // random back-to-back and gapped traffic
    for (int i = 0; i < 40; i++) begin
      issue8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 12)) begin @(posedge clk); #1; end
    end
    for (int i = 0; i < 20; i++)
      issue1(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

    begin
      int n = 0;
      while ((q8.size() != 0 || q1.size() != 0) && n < 200) begin
        @(posedge clk); #1; n++;
      end
    end
    if (q8.size() != 0 || q1.size() != 0) begin
      nchk++; nbad++;
      $display("FAIL drain: got %0d results outstanding expected 0", q8.size() + q1.size());
    end
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nbad);
    $finish;
  end

endmodule
